alu_instr_sequencer: RTL and testbench

- Control-step sequencer for CPU_Datapath; produces every datapath control strobe to fetch one instruction and execute one register-register ALU instruction.
- Steps: T0 (PC to MAR, PC+1), T1 (memory read), T2 (IR load), T3 (Rb to Y), T4 (ALU op into Z), T5 (result writeback), T6 (high-half writeback, mul/div only).
- Replaces per-state manual strobe driving in benches; later extended for load/store/branch.

---
 rtl/alu_instr_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer: drives every CPU_Datapath strobe to fetch and run one reg-reg ALU instruction.
// Latency: T0..T5 then DONE (6 cycles), 7 for mul/div, +1 per memory wait cycle; outputs decoded from state.
// Backpressure: mem_ready low holds the sequencer in T1W (Read/MDRin held) with no timeout; start only taken in IDLE.
module alu_instr_sequencer #(
  parameter logic [4:0] MUL_OP = 5'b01111,
  parameter logic [4:0] DIV_OP = 5'b10000,
  parameter logic [4:0] MAX_OP = 5'b10000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        continuous,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Yout,
  output logic        Zin,
  output logic        ZLOin,
  output logic        ZHIin,
  output logic        ZLowSelect,
  output logic        ZHighSelect,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        Loin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  ALUSelection,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_DONE = 4'd9,
    S_ILL  = 4'd10
  } state_t;

  state_t cur_st;
  state_t nxt_st;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       wide_op;
  logic       illegal_op;
  logic       unused_ir;

  // IR fields are only meaningful from T3 onward; the low 15 bits carry no register-register information.
  assign opcode     = IR[31:27];
  assign ra         = IR[26:23];
  assign rb         = IR[22:19];
  assign rc         = IR[18:15];
  assign unused_ir  = ^IR[14:0];
  assign wide_op    = (opcode == MUL_OP) || (opcode == DIV_OP);
  assign illegal_op = (opcode > MAX_OP);
  assign state      = cur_st;

  // State register; clr drops straight to IDLE so no partial step can finish.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur_st <= S_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // Next-state and strobe decode; every strobe is a pure function of state (plus IR in T3..T6).
  always_comb begin
    nxt_st       = cur_st;
    PCout        = 1'b0;
    MARin        = 1'b0;
    IncPC        = 1'b0;
    PCin         = 1'b0;
    Read         = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    Yout         = 1'b0;
    Zin          = 1'b0;
    ZLOin        = 1'b0;
    ZHIin        = 1'b0;
    ZLowSelect   = 1'b0;
    ZHighSelect  = 1'b0;
    ZLOout       = 1'b0;
    ZHIout       = 1'b0;
    HIin         = 1'b0;
    Loin         = 1'b0;
    Rin          = 16'h0000;
    Rout         = 16'h0000;
    ALUSelection = 5'b00000;
    busy         = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (cur_st)
      S_IDLE: begin
        if (start) nxt_st = S_T0;
      end
      S_T0: begin
        busy       = 1'b1;
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        ZLOin      = 1'b1;
        ZLowSelect = 1'b1;
        nxt_st     = S_T1;
      end
      S_T1: begin
        busy   = 1'b1;
        ZLOout = 1'b1;
        PCin   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
        nxt_st = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        // PC was already written in T1; only the memory read is held here.
        busy   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
        if (mem_ready) nxt_st = S_T2;
      end
      S_T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
        nxt_st = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (illegal_op) begin
          nxt_st = S_ILL;
        end else begin
          Rout   = 16'd1 << rb;
          Yin    = 1'b1;
          nxt_st = S_T4;
        end
      end
      S_T4: begin
        busy         = 1'b1;
        Yout         = 1'b1;
        Rout         = 16'd1 << rc;
        ALUSelection = opcode;
        Zin          = 1'b1;
        ZLOin        = 1'b1;
        ZLowSelect   = 1'b1;
        ZHIin        = wide_op;
        ZHighSelect  = wide_op;
        nxt_st       = S_T5;
      end
      S_T5: begin
        busy   = 1'b1;
        ZLOout = 1'b1;
        if (wide_op) begin
          Loin   = 1'b1;
          nxt_st = S_T6;
        end else begin
          Rin    = 16'd1 << ra;
          nxt_st = S_DONE;
        end
      end
      S_T6: begin
        busy   = 1'b1;
        ZHIout = 1'b1;
        HIin   = 1'b1;
        nxt_st = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        nxt_st = continuous ? S_T0 : S_IDLE;
      end
      S_ILL: begin
        illegal = 1'b1;
        nxt_st  = S_IDLE;
      end
      default: begin
        nxt_st = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: builds the expected per-cycle strobe trace of each instruction from its opcode,
// register fields and memory wait count, then replays the inputs and compares every output cycle by cycle.
// Directed cases pin the trace builder with literal values; a final case exercises clr mid-instruction.
module tb_alu_instr_sequencer;

  localparam logic [4:0] MUL_OP = 5'b01111;
  localparam logic [4:0] DIV_OP = 5'b10000;
  localparam logic [4:0] MAX_OP = 5'b10000;

  logic        clk = 1'b0;
  logic        clr, start, continuous, mem_ready;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Yout, Zin, ZLOin, ZHIin;
  logic ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALUSelection;
  logic        busy, done, illegal;
  logic [3:0]  state;

  typedef struct packed {
    logic pcout, marin, incpc, pcin, read, mdrin, mdrout, irin, yin, yout, zin, zloin, zhiin;
    logic zlowsel, zhighsel, zloout, zhiout, hiin, loin;
    logic [15:0] rin, rout;
    logic [4:0]  alu;
    logic        busy, done, illegal;
    logic [3:0]  st;
  } outs_t;

  typedef struct packed {
    logic        start, cont, mrdy;
    logic [31:0] ir;
    outs_t       e;
  } rec_t;

  rec_t  q[$];
  outs_t act;
  int    checks = 0;
  int    errors = 0;

  assign act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Yout, Zin, ZLOin, ZHIin,
                ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin, Rin, Rout, ALUSelection,
                busy, done, illegal, state};

  alu_instr_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .continuous(continuous), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Yout(Yout), .Zin(Zin), .ZLOin(ZLOin), .ZHIin(ZHIin),
    .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .Loin(Loin), .Rin(Rin), .Rout(Rout), .ALUSelection(ALUSelection),
    .busy(busy), .done(done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // One cycle of the trace; inputs that the design must ignore in this step are randomized.
  function automatic rec_t blank(input logic [3:0] st, input logic [31:0] ir);
    rec_t r;
    r        = '0;
    r.ir     = ir;
    r.e.st   = st;
    r.e.busy = (st >= 4'd1) && (st <= 4'd8);
    r.start  = 1'($urandom_range(0, 1));
    r.cont   = 1'($urandom_range(0, 1));
    r.mrdy   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic add_idle(input int n, input logic go, input logic [31:0] ir);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r       = blank(4'd0, ir);
      r.e.busy = 1'b0;
      r.start = go && (i == n - 1);
      q.push_back(r);
    end
  endtask

  // Expected cycle sequence of one instruction, from fetch through DONE/ILL.
  task automatic add_instr(input logic [31:0] ir, input int waits, input logic cont);
    rec_t r;
    logic [4:0] op;
    logic       wide;
    op   = ir[31:27];
    wide = (op == MUL_OP) || (op == DIV_OP);
    r = blank(4'd1, ir);
    r.e.pcout = 1; r.e.marin = 1; r.e.incpc = 1; r.e.zin = 1; r.e.zloin = 1; r.e.zlowsel = 1;
    q.push_back(r);
    r = blank(4'd2, ir);
    r.e.zloout = 1; r.e.pcin = 1; r.e.read = 1; r.e.mdrin = 1; r.mrdy = (waits == 0);
    q.push_back(r);
    for (int j = 0; j < waits; j++) begin
      r = blank(4'd3, ir);
      r.e.read = 1; r.e.mdrin = 1; r.mrdy = (j == waits - 1);
      q.push_back(r);
    end
    r = blank(4'd4, ir);
    r.e.mdrout = 1; r.e.irin = 1;
    q.push_back(r);
    if (op > MAX_OP) begin
      q.push_back(blank(4'd5, ir));
      r = blank(4'd10, ir);
      r.e.illegal = 1; r.cont = cont;
      q.push_back(r);
    end else begin
      r = blank(4'd5, ir);
      r.e.rout = 16'd1 << ir[22:19]; r.e.yin = 1;
      q.push_back(r);
      r = blank(4'd6, ir);
      r.e.yout = 1; r.e.rout = 16'd1 << ir[18:15]; r.e.alu = op;
      r.e.zin = 1; r.e.zloin = 1; r.e.zlowsel = 1; r.e.zhiin = wide; r.e.zhighsel = wide;
      q.push_back(r);
      r = blank(4'd7, ir);
      r.e.zloout = 1;
      if (wide) r.e.loin = 1;
      else r.e.rin = 16'd1 << ir[26:23];
      q.push_back(r);
      if (wide) begin
        r = blank(4'd8, ir);
        r.e.zhiout = 1; r.e.hiin = 1;
        q.push_back(r);
      end
      r = blank(4'd9, ir);
      r.e.done = 1; r.cont = cont;
      q.push_back(r);
    end
  endtask

  initial begin
    int base, n_w, n_pc, n_rd, n_busy, n_done;
    logic [31:0] ir, prev_ir;
    logic [4:0]  op;
    logic        chain, c;
    int          w;

    clr = 1'b1; start = 1'b0; continuous = 1'b0; mem_ready = 1'b1; IR = 32'h0;
    #2 clr = 1'b0;
    #1 chk("reset_outputs", 64'(act), 64'h0);

    // ---- directed: ordinary op, no waits ----
    add_idle(2, 1'b1, 32'h0);
    base = q.size();
    add_instr(32'h28918000, 0, 1'b0);
    chk("pin_len_ord", 64'(q.size() - base), 64'd7);
    chk("pin_t3_rout", 64'(q[base+3].e.rout), 64'h0004);
    chk("pin_t3_yin", 64'(q[base+3].e.yin), 64'h1);
    chk("pin_t4_rout", 64'(q[base+4].e.rout), 64'h0008);
    chk("pin_t4_alu", 64'(q[base+4].e.alu), 64'h05);
    chk("pin_t5_rin", 64'(q[base+5].e.rin), 64'h0002);
    chk("pin_t5_zloout", 64'(q[base+5].e.zloout), 64'h1);
    n_done = 0;
    for (int i = base; i < q.size(); i++) n_done += int'(q[i].e.done);
    chk("pin_done_once", 64'(n_done), 64'd1);

    // ---- directed: three memory wait cycles ----
    add_idle(2, 1'b1, 32'h28918000);
    base = q.size();
    add_instr(32'h28918000, 3, 1'b0);
    n_w = 0; n_pc = 0; n_rd = 0;
    for (int i = base; i < q.size(); i++) begin
      n_w  += int'(q[i].e.st == 4'd3);
      n_pc += int'(q[i].e.pcin);
      n_rd += int'(q[i].e.read && q[i].e.mdrin);
    end
    chk("pin_t1w_cycles", 64'(n_w), 64'd3);
    chk("pin_pcin_once", 64'(n_pc), 64'd1);
    chk("pin_read_cycles", 64'(n_rd), 64'd4);

    // ---- directed: MUL ----
    add_idle(1, 1'b1, 32'h28918000);
    base = q.size();
    add_instr(32'h7A118000, 0, 1'b0);
    n_busy = 0;
    for (int i = base; i < q.size(); i++) n_busy += int'(q[i].e.busy);
    chk("pin_mul_busy", 64'(n_busy), 64'd7);
    chk("pin_mul_t4", 64'({q[base+4].e.zhiin, q[base+4].e.zhighsel, q[base+4].e.rout}), 64'h30008);
    chk("pin_mul_t5", 64'({q[base+5].e.loin, q[base+5].e.rin}), 64'h10000);
    chk("pin_mul_t6", 64'({q[base+6].e.zhiout, q[base+6].e.hiin}), 64'h3);

    // ---- directed: illegal opcode with continuous held high ----
    add_idle(1, 1'b1, 32'h7A118000);
    add_instr(32'hF8000000, 0, 1'b1);
    add_idle(3, 1'b0, 32'hF8000000);

    // ---- directed: back-to-back with continuous, start noise while busy ----
    add_idle(1, 1'b1, 32'hF8000000);
    add_instr(32'h28918000, 1, 1'b1);
    add_instr(32'h80A18000, 0, 1'b0);

    // ---- randomized instructions ----
    chain = 1'b0;
    prev_ir = 32'h80A18000;
    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 20));
      if (op > 5'd16) op = 5'($urandom_range(17, 31));
      ir = {op, 27'($urandom)};
      w  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      c  = (k == 59) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!chain) add_idle(int'($urandom_range(1, 3)), 1'b1, prev_ir);
      add_instr(ir, w, c);
      chain = c && (op <= MAX_OP);
      prev_ir = ir;
    end
    add_idle(2, 1'b0, prev_ir);

    // ---- replay trace against the DUT ----
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = q[i].start; continuous = q[i].cont; mem_ready = q[i].mrdy; IR = q[i].ir;
      #1;
      checks++;
      if (act !== q[i].e) begin
        errors++;
        $display("FAIL trace[%0d] step %0d: got %h want %h", i, q[i].e.st, act, q[i].e);
      end
    end

    // ---- clr asserted mid-T4 ----
    @(negedge clk);
    IR = 32'h28918000; start = 1'b1; mem_ready = 1'b1; continuous = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("clr_pre_state", 64'(state), 64'd6);
    #1 clr = 1'b0;
    #1 chk("clr_async_outputs", 64'(act), 64'h0);
    @(negedge clk);
    #1 chk("clr_held_outputs", 64'(act), 64'h0);
    clr = 1'b1; continuous = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("post_clr_idle", 64'(act), 64'h0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("post_clr_start", 64'({busy, state}), 64'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
